dap_cfg_sequencer: RTL

AXI4-Lite master that configures the `dap` image-filter slave (four 32-bit registers at offsets 0x0–0xC) from a local shadow table. On a `start` pulse it writes every table entry to consecutive word addresses. When compiled with readback, it then reads each register back and compares it with the table. It reports completion and errors to the host-side control logic and sits between that logic and the `S00_AXI` port of `dap`.

---
 rtl/dap_cfg_sequencer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dap_cfg_sequencer.sv
// AXI4-Lite master that loads the dap filter registers from a shadow table.
// Optional readback/compare pass is built when DAP_CFG_READBACK_EN is defined.
module dap_cfg_sequencer #(
   parameter int unsigned NUM_REGS       = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [IW-1:0]         err_index,
   input  logic                  tbl_we,
   input  logic [IW-1:0]         tbl_idx,
   input  logic [31:0]           tbl_wdata,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [31:0]           M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [31:0]           M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   typedef enum logic [2:0] {
      S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_FIN
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [IW-1:0]         r_idx, w_idx_nxt, w_idx_inc;
   logic [CW-1:0]         r_cnt, w_cnt_nxt;
   logic                  r_awvalid, w_awv_nxt;
   logic                  r_wvalid, w_wv_nxt;
   logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
   logic [31:0]           r_wdata, w_wdata_nxt;
   logic                  r_error, w_error_nxt;
   logic [1:0]            r_code, w_code_nxt;
   logic [IW-1:0]         r_eidx, w_eidx_nxt;
   logic [31:0]           r_tbl [NUM_REGS];
   logic [31:0]           w_tbl0;
   logic                  w_fail, w_tout, w_wait, w_last;
   logic                  w_aw_ok, w_w_ok;
   logic [1:0]            w_fcode;
`ifdef DAP_CFG_READBACK_EN
   logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
`else
   logic                  w_unused;
`endif

   function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [IW-1:0] i);
      return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'({i, 2'b00});
   endfunction

   assign w_idx_inc = r_idx + 1'b1;
   assign w_last    = (r_idx == IW'(NUM_REGS - 1));
   assign w_tout    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_wait    = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                      (r_state == S_RADDR) || (r_state == S_RDATA);
   assign w_aw_ok   = !r_awvalid || M_AXI_AWREADY;
   assign w_w_ok    = !r_wvalid || M_AXI_WREADY;
   // A table write in the start cycle must reach the first beat.
   assign w_tbl0    = (tbl_we && tbl_idx == '0) ? tbl_wdata : r_tbl[0];

   assign busy          = (r_state != S_IDLE);
   assign done          = (r_state == S_FIN);
   assign error         = r_error;
   assign err_code      = r_code;
   assign err_index     = r_eidx;
   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = (r_state == S_WRESP);
   assign M_AXI_ARPROT  = 3'b000;
`ifdef DAP_CFG_READBACK_EN
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARVALID = (r_state == S_RADDR);
   assign M_AXI_RREADY  = (r_state == S_RDATA);
`else
   assign M_AXI_ARADDR  = '0;
   assign M_AXI_ARVALID = 1'b0;
   assign M_AXI_RREADY  = 1'b0;
   assign w_unused = ^{M_AXI_ARREADY, M_AXI_RDATA,
                       M_AXI_RRESP, M_AXI_RVALID};
`endif

   // Shadow table: host writes land only while idle.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_tbl[i] <= '0;
      end else if (tbl_we && r_state == S_IDLE &&
                   32'(tbl_idx) < NUM_REGS) begin
         r_tbl[tbl_idx] <= tbl_wdata;
      end
   end

   // Sequencer next-state, channel payloads and error capture.
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_awv_nxt    = r_awvalid;
      w_wv_nxt     = r_wvalid;
      w_awaddr_nxt = r_awaddr;
      w_wdata_nxt  = r_wdata;
      w_error_nxt  = r_error;
      w_code_nxt   = r_code;
      w_eidx_nxt   = r_eidx;
      w_fail       = 1'b0;
      w_fcode      = 2'd0;
`ifdef DAP_CFG_READBACK_EN
      w_araddr_nxt = r_araddr;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt  = S_WADDR;
               w_idx_nxt    = '0;
               w_error_nxt  = 1'b0;
               w_code_nxt   = 2'd0;
               w_eidx_nxt   = '0;
               w_awv_nxt    = 1'b1;
               w_wv_nxt     = 1'b1;
               w_awaddr_nxt = f_addr('0);
               w_wdata_nxt  = w_tbl0;
            end
         end
         S_WADDR: begin
            if (M_AXI_AWREADY) w_awv_nxt = 1'b0;
            if (M_AXI_WREADY)  w_wv_nxt  = 1'b0;
            if (w_aw_ok && w_w_ok) begin
               w_state_nxt = S_WRESP;
            end else if (w_tout) begin
               w_fail  = 1'b1;
               w_fcode = 2'd3;
            end
         end
         S_WRESP: begin
            if (M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  w_fail  = 1'b1;
                  w_fcode = 2'd1;
               end else if (w_last) begin
                  w_idx_nxt = '0;
`ifdef DAP_CFG_READBACK_EN
                  w_state_nxt  = S_RADDR;
                  w_araddr_nxt = f_addr('0);
`else
                  w_state_nxt = S_FIN;
`endif
               end else begin
                  w_idx_nxt    = w_idx_inc;
                  w_state_nxt  = S_WADDR;
                  w_awv_nxt    = 1'b1;
                  w_wv_nxt     = 1'b1;
                  w_awaddr_nxt = f_addr(w_idx_inc);
                  w_wdata_nxt  = r_tbl[w_idx_inc];
               end
            end else if (w_tout) begin
               w_fail  = 1'b1;
               w_fcode = 2'd3;
            end
         end
`ifdef DAP_CFG_READBACK_EN
         S_RADDR: begin
            if (M_AXI_ARREADY) begin
               w_state_nxt = S_RDATA;
            end else if (w_tout) begin
               w_fail  = 1'b1;
               w_fcode = 2'd3;
            end
         end
         S_RDATA: begin
            if (M_AXI_RVALID) begin
               if (M_AXI_RRESP != 2'b00) begin
                  w_fail  = 1'b1;
                  w_fcode = 2'd1;
               end else if (M_AXI_RDATA != r_tbl[r_idx]) begin
                  w_fail  = 1'b1;
                  w_fcode = 2'd2;
               end else if (w_last) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_idx_nxt    = w_idx_inc;
                  w_state_nxt  = S_RADDR;
                  w_araddr_nxt = f_addr(w_idx_inc);
               end
            end else if (w_tout) begin
               w_fail  = 1'b1;
               w_fcode = 2'd3;
            end
         end
`else
         S_RADDR: w_state_nxt = S_IDLE;
         S_RDATA: w_state_nxt = S_IDLE;
`endif
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_fail) begin
         w_state_nxt = S_FIN;
         w_error_nxt = 1'b1;
         w_code_nxt  = w_fcode;
         w_eidx_nxt  = r_idx;
         w_awv_nxt   = 1'b0;
         w_wv_nxt    = 1'b0;
      end
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
      else if (w_wait)            w_cnt_nxt = r_cnt + 1'b1;
      else                        w_cnt_nxt = '0;
   end

   // Sequencer state register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_error   <= 1'b0;
         r_code    <= 2'd0;
         r_eidx    <= '0;
`ifdef DAP_CFG_READBACK_EN
         r_araddr  <= '0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_awvalid <= w_awv_nxt;
         r_wvalid  <= w_wv_nxt;
         r_awaddr  <= w_awaddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_error   <= w_error_nxt;
         r_code    <= w_code_nxt;
         r_eidx    <= w_eidx_nxt;
`ifdef DAP_CFG_READBACK_EN
         r_araddr  <= w_araddr_nxt;
`endif
      end
   end

endmodule
